// File: rtl/axis_frame_fifo.sv
// axis_frame_fifo: store-and-forward AXI-Stream frame FIFO reporting level, frame count and drops.
// Define AXIS_FRAME_FIFO_DROP_OVERSIZE_EN to discard frames that overflow the buffer;
// without it an oversize frame is force-committed and drains cut-through.
module axis_frame_fifo #(
    parameter int G_DATAWIDTH = 32,
    parameter int G_DEPTH     = 1024,
    parameter int G_ADDRWIDTH = $clog2(G_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [G_DATAWIDTH-1:0] s_axis_tdata,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    output logic [G_DATAWIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic [G_ADDRWIDTH:0]   level,
    output logic [G_ADDRWIDTH:0]   frames,
    output logic                   drop
);
    localparam logic [G_ADDRWIDTH:0] L_DEPTH = (G_ADDRWIDTH+1)'(G_DEPTH);
`ifdef AXIS_FRAME_FIFO_DROP_OVERSIZE_EN
    typedef enum logic [1:0] {S_IDLE, S_FRAME, S_DROP} state_t;
`else
    typedef enum logic {S_IDLE, S_FRAME} state_t;
`endif
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [G_DATAWIDTH:0]   r_mem [G_DEPTH];
    logic [G_ADDRWIDTH:0]   r_wr_ptr;
    logic [G_ADDRWIDTH:0]   r_rd_ptr;
    logic [G_ADDRWIDTH:0]   r_commit_ptr;
    logic [G_ADDRWIDTH:0]   r_frames;
    logic [G_DATAWIDTH-1:0] r_out_data;
    logic                   r_out_valid;
    logic                   r_out_last;
    logic                   r_init;
    logic [G_ADDRWIDTH:0]   w_used;
    logic                   w_full;
    logic                   w_in_xfer;
    logic                   w_wr_xfer;
    logic                   w_commit;
    logic                   w_force;
    logic                   w_drop;
    logic                   w_discard;
    logic                   w_rd_xfer;
    logic                   w_load;

    assign w_used = r_wr_ptr - r_rd_ptr;
    assign w_full = w_used == L_DEPTH;
`ifdef AXIS_FRAME_FIFO_DROP_OVERSIZE_EN
    assign w_drop    = (r_state == S_FRAME) && w_full;
    assign w_discard = r_state == S_DROP;
    assign w_force   = 1'b0;
`else
    assign w_drop    = 1'b0;
    assign w_discard = 1'b0;
    assign w_force   = w_full && (r_commit_ptr == r_rd_ptr);
`endif
    assign s_axis_tready = r_init && (!w_full || w_discard);
    assign w_in_xfer     = s_axis_tvalid && s_axis_tready;
    assign w_wr_xfer     = w_in_xfer && !w_discard;
    assign w_commit      = w_wr_xfer && s_axis_tlast;
    assign w_rd_xfer     = r_out_valid && m_axis_tready;
    assign w_load        = (!r_out_valid || m_axis_tready) && (r_rd_ptr != r_commit_ptr);

    assign m_axis_tdata  = r_out_data;
    assign m_axis_tvalid = r_out_valid;
    assign m_axis_tlast  = r_out_last;
    assign level         = w_used + (G_ADDRWIDTH+1)'(r_out_valid);
    assign frames        = r_frames;
    assign drop          = w_drop;

    // next write-frame state: track whether we are inside a frame (or discarding one)
    always_comb begin
        w_state_nxt = r_state;
`ifdef AXIS_FRAME_FIFO_DROP_OVERSIZE_EN
        if (w_drop)
            w_state_nxt = S_DROP;
        else if (w_in_xfer)
            w_state_nxt = s_axis_tlast ? S_IDLE : (w_discard ? S_DROP : S_FRAME);
`else
        if (w_in_xfer)
            w_state_nxt = s_axis_tlast ? S_IDLE : S_FRAME;
`endif
    end

    // beat storage, entry is {tlast,tdata}; no reset needed for RAM contents
    always_ff @(posedge clk) begin
        if (w_wr_xfer)
            r_mem[r_wr_ptr[G_ADDRWIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end

    // pointers, frame counter, output register and write state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_commit_ptr <= '0;
            r_frames     <= '0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_init       <= 1'b0;
        end else begin
            r_init  <= 1'b1;
            r_state <= w_state_nxt;
            if (w_drop)
                r_wr_ptr <= r_commit_ptr;
            else if (w_wr_xfer)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_commit)
                r_commit_ptr <= r_wr_ptr + 1'b1;
            else if (w_force)
                r_commit_ptr <= r_wr_ptr;
            r_frames <= r_frames + (G_ADDRWIDTH+1)'(w_commit)
                                 - (G_ADDRWIDTH+1)'(w_rd_xfer && r_out_last);
            if (w_load) begin
                {r_out_last, r_out_data} <= r_mem[r_rd_ptr[G_ADDRWIDTH-1:0]];
                r_out_valid <= 1'b1;
                r_rd_ptr    <= r_rd_ptr + 1'b1;
            end else if (w_rd_xfer) begin
                r_out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axis_frame_fifo.sv
// tb_axis_frame_fifo: directed and randomised frame traffic against a queue-based model of axis_frame_fifo.
// Honours AXIS_FRAME_FIFO_DROP_OVERSIZE_EN to pick the oversize-frame scenario.
module tb_axis_frame_fifo;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic [4:0]  level;
    logic [4:0]  frames;
    logic        drop;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [32:0] exp_q[$];
    logic [32:0] exp_e;
    logic [32:0] prev_out;
    bit          prev_stall = 0;
    bit          prev_drop = 0;
    bit          discarding = 0;
    int          mdl_level = 0;
    int          mdl_frames = 0;
    int          cur_beats = 0;
    int          n_out = 0;
    int          n_out_last = 0;
    int          n_drop = 0;
    int          last_acc = 0;
    int          first_v = -1;
    logic [31:0] last_out_data = '0;

    axis_frame_fifo #(.G_DATAWIDTH(32), .G_DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .level(level), .frames(frames), .drop(drop)
    );

    always #5 clk = ~clk;

    // cycle counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
    endtask

    // model: every accepted beat is owed to the output in order; level/frames follow from counts
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            mdl_level  = 0;
            mdl_frames = 0;
            cur_beats  = 0;
            discarding = 0;
            prev_stall = 0;
            prev_drop  = 0;
        end else begin
            check("level", 64'(level), 64'(mdl_level));
            check("frames", 64'(frames), 64'(mdl_frames));
`ifdef AXIS_FRAME_FIFO_DROP_OVERSIZE_EN
            check("drop_one_cycle", 64'(drop && prev_drop), 64'd0);
`else
            check("drop_low", 64'(drop), 64'd0);
`endif
            if (prev_stall) begin
                check("hold_valid", 64'(m_tvalid), 64'd1);
                check("hold_beat", 64'({m_tlast, m_tdata}), 64'(prev_out));
            end
            if (m_tvalid && first_v < 0)
                first_v = cyc;
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'({m_tlast, m_tdata}), 64'h1_dead_beef);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("out_data", 64'(m_tdata), 64'(exp_e[31:0]));
                    check("out_last", 64'(m_tlast), 64'(exp_e[32]));
                    mdl_level--;
                    if (exp_e[32]) mdl_frames--;
                end
                n_out++;
                if (m_tlast) n_out_last++;
                last_out_data = m_tdata;
            end
            if (drop) begin
                n_drop++;
                repeat (cur_beats) void'(exp_q.pop_back());
                mdl_level -= cur_beats;
                cur_beats  = 0;
                discarding = 1;
            end
            if (s_tvalid && s_tready) begin
                if (discarding) begin
                    if (s_tlast) discarding = 0;
                end else begin
                    exp_q.push_back({s_tlast, s_tdata});
                    mdl_level++;
                    if (s_tlast) begin
                        mdl_frames++;
                        cur_beats = 0;
                        last_acc  = cyc;
                    end else begin
                        cur_beats++;
                    end
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_out   = {m_tlast, m_tdata};
            prev_drop  = drop;
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic l, input int gap, input bit gate);
        int t = 0;
        s_tvalid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
`ifdef AXIS_FRAME_FIFO_DROP_OVERSIZE_EN
        while (gate && mdl_level >= 12) begin
            @(posedge clk); #1;
        end
`endif
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        while (!s_tready) begin
            @(posedge clk); #1;
            if (++t > 2000) begin
                timeout("send_beat");
                break;
            end
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [31:0] base, input bit rnd);
        for (int i = 0; i < n; i++)
            send_beat(rnd ? $urandom : base + 32'(i), i == n - 1,
                      rnd ? int'($urandom_range(0, 3) == 0) : 0, rnd);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 || m_tvalid) begin
            @(posedge clk); #1;
            if (++t > 3000) begin
                timeout("drain");
                break;
            end
        end
    endtask

    bit rnd_on;
    int n0;
    int l0;

    initial begin
        rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tready", 64'(s_tready), 64'd0);
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_tdata", 64'({m_tlast, m_tdata}), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_frames", 64'(frames), 64'd0);
        check("rst_drop", 64'(drop), 64'd0);
        rst = 1'b0;
        check("tready_before_edge", 64'(s_tready), 64'd0);
        @(posedge clk); #1;
        check("tready_after_edge", 64'(s_tready), 64'd1);

        m_tready = 1'b1;
        for (int i = 0; i < 3; i++) send_beat(32'hA0 + 32'(i), 1'b0, 0, 0);
        check("midframe_level", 64'(level), 64'd3);
        rst = 1'b1;
        #1;
        check("midframe_rst_level", 64'(level), 64'd0);
        check("midframe_rst_frames", 64'(frames), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        first_v = -1;
        n0 = n_out;
        send_frame(4, 32'h1, 0);
        check("t1_frames_committed", 64'(frames), 64'd1);
        drain();
        check("t1_latency", 64'(first_v - last_acc), 64'd2);
        check("t1_beats_out", 64'(n_out - n0), 64'd4);
        check("t1_last_data", 64'(last_out_data), 64'h4);
        check("t1_frames_end", 64'(frames), 64'd0);

        m_tready = 1'b0;
        for (int f = 0; f < 3; f++) send_frame(5, 32'h200 + 32'(16 * f), 0);
        repeat (3) @(posedge clk);
        #1;
        check("t2_level", 64'(level), 64'd15);
        check("t2_frames", 64'(frames), 64'd3);
        check("t2_tready", 64'(s_tready), 64'd1);
        n0 = n_out; l0 = n_out_last;
        m_tready = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("t2_contiguous", 64'(n_out - n0), 64'd15);
        check("t2_lasts", 64'(n_out_last - l0), 64'd3);
        check("t2_empty", 64'(m_tvalid), 64'd0);

        rnd_on = 1;
        fork
            begin
                for (int f = 0; f < 200; f++) send_frame(int'($urandom_range(1, 12)), 32'h0, 1);
                rnd_on = 0;
            end
            while (rnd_on) begin
                @(posedge clk); #1;
                m_tready = $urandom_range(0, 2) != 0;
            end
        join
        m_tready = 1'b1;
        drain();
        check("t3_level_end", 64'(level), 64'd0);
        check("t3_frames_end", 64'(frames), 64'd0);

        n0 = n_out;
        for (int i = 0; i < 40; i++) begin
            send_beat(32'h400 + 32'(i), 1'b1, 0, 0);
            if (i == 20) begin
                check("t4_level_mid", 64'(level), 64'd2);
                check("t4_frames_mid", 64'(frames), 64'd2);
            end
        end
        check("t4_out_rate", 64'(n_out - n0), 64'd38);
        check("t4_level_end", 64'(level), 64'd2);
        check("t4_frames_end", 64'(frames), 64'd2);
        drain();

        m_tready = 1'b0;
        n0 = n_out; l0 = n_out_last;
`ifdef AXIS_FRAME_FIFO_DROP_OVERSIZE_EN
        send_frame(20, 32'h600, 0);
        send_frame(3, 32'h700, 0);
        repeat (3) @(posedge clk);
        #1;
        check("t6_level", 64'(level), 64'd3);
        check("t6_frames", 64'(frames), 64'd1);
        check("t6_drops", 64'(n_drop), 64'd1);
        m_tready = 1'b1;
        drain();
        check("t6_beats_out", 64'(n_out - n0), 64'd3);
        check("t6_last_data", 64'(last_out_data), 64'h702);
`else
        fork
            send_frame(20, 32'h500, 0);
            begin
                int t = 0;
                while (s_tready) begin
                    @(posedge clk); #1;
                    if (++t > 200) begin
                        timeout("t5_full");
                        break;
                    end
                end
                check("t5_level_full", 64'(level), 64'd16);
                check("t5_frames_full", 64'(frames), 64'd0);
                repeat (5) @(posedge clk);
                #1;
                m_tready = 1'b1;
            end
        join
        drain();
        check("t5_beats_out", 64'(n_out - n0), 64'd20);
        check("t5_lasts", 64'(n_out_last - l0), 64'd1);
        check("t5_last_data", 64'(last_out_data), 64'h513);
        check("t5_drops", 64'(n_drop), 64'd0);
`endif
        check("final_level", 64'(level), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
